// File: rtl/lif_row_updater.sv
// LIF row sweep: read 16 potentials+betas, add a current row, threshold, write back. 4 cycles/row;
// backpressure: the sweep waits in CALC (cur_ready high) until cur_valid, each wait cycle adds one.
module lif_row_updater #(
  parameter int NEURONS = 16,
  parameter int PW      = 8,
  parameter int BW      = 4,
  parameter int AW      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW-1:0]         num_rows,
  input  logic [PW-1:0]         threshold,
  input  logic [NEURONS*PW-1:0] potential_read_out,
  input  logic [NEURONS*BW-1:0] beta_read_out,
  input  logic [NEURONS*PW-1:0] cur_in,
  input  logic                  cur_valid,
  output logic                  cur_ready,
  output logic [AW-1:0]         cntrl_potential_read_addr,
  output logic [AW-1:0]         cntrl_beta_read_addr,
  output logic [AW-1:0]         cntrl_potential_write_addr,
  output logic [NEURONS*PW-1:0] potential_write_in,
  output logic                  potential_write_en,
  output logic [NEURONS-1:0]    spk_row,
  output logic                  spk_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_CALC, S_WRITE, S_DONE
  } state_t;

  localparam logic signed [PW+1:0] SAT_MAX = {3'b000, {(PW-1){1'b1}}};
  localparam logic signed [PW+1:0] SAT_MIN = {3'b111, {(PW-1){1'b0}}};
  localparam logic [BW-1:0]        MAX_SH  = BW'(7);

  state_t state, state_n;

  logic [AW-1:0]         base_r, rows_r, row_idx;
  logic signed [PW-1:0]  thr_r;
  logic [NEURONS*PW-1:0] pot_r;
  logic [NEURONS*BW-1:0] beta_r;
  logic                  last_row, sweep_go, cur_hs;

  logic [AW-1:0]         rd_addr_n, wr_addr_n;
  logic [NEURONS*PW-1:0] wdata_n, calc_pot;
  logic [NEURONS-1:0]    spk_n, calc_spk;
  logic                  busy_n, done_n, ready_n, wen_n;

  logic signed [PW-1:0]  v, c, leak, sat;
  logic [BW-1:0]         b;
  logic [2:0]            sh;
  logic signed [PW+1:0]  sum;

  assign last_row             = (row_idx == rows_r - AW'(1));
  assign sweep_go             = (state == S_IDLE) && start && (num_rows != '0);
  assign cur_hs               = (state == S_CALC) && cur_valid;
  assign cntrl_beta_read_addr = cntrl_potential_read_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = (num_rows == '0) ? S_DONE : S_READ;
      S_READ:  state_n = S_LATCH;
      S_LATCH: state_n = S_CALC;
      S_CALC:  if (cur_valid) state_n = S_WRITE;
      S_WRITE: state_n = last_row ? S_DONE : S_READ;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed off the upcoming state.
  always_comb begin
    rd_addr_n = cntrl_potential_read_addr;
    wr_addr_n = cntrl_potential_write_addr;
    wdata_n   = potential_write_in;
    spk_n     = spk_row;
    if (sweep_go)
      rd_addr_n = base_addr;
    else if (state == S_WRITE && !last_row)
      rd_addr_n = base_r + row_idx + AW'(1);
    if (state_n == S_WRITE)
      wr_addr_n = cntrl_potential_read_addr;
    if (cur_hs) begin
      wdata_n = calc_pot;
      spk_n   = calc_spk;
    end else if (state == S_WRITE) begin
      spk_n   = '0;
    end
    ready_n = (state_n == S_CALC);
    wen_n   = (state_n == S_WRITE);
    done_n  = (state_n == S_DONE);
    busy_n  = (state_n == S_READ) || (state_n == S_LATCH) || (state_n == S_CALC) ||
              (state_n == S_WRITE) || (state_n == S_DONE && state == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntrl_potential_read_addr  <= '0;
      cntrl_potential_write_addr <= '0;
      potential_write_in         <= '0;
      potential_write_en         <= 1'b0;
      spk_row                    <= '0;
      spk_valid                  <= 1'b0;
      cur_ready                  <= 1'b0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
    end else begin
      cntrl_potential_read_addr  <= rd_addr_n;
      cntrl_potential_write_addr <= wr_addr_n;
      potential_write_in         <= wdata_n;
      potential_write_en         <= wen_n;
      spk_row                    <= spk_n;
      spk_valid                  <= wen_n;
      cur_ready                  <= ready_n;
      busy                       <= busy_n;
      done                       <= done_n;
    end
  end

  // Sweep context is sampled once at start so mid-sweep input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r  <= '0;
      rows_r  <= '0;
      thr_r   <= '0;
      row_idx <= '0;
      pot_r   <= '0;
      beta_r  <= '0;
    end else begin
      if (sweep_go) begin
        base_r  <= base_addr;
        rows_r  <= num_rows;
        thr_r   <= threshold;
        row_idx <= '0;
      end else if (state == S_WRITE) begin
        row_idx <= row_idx + AW'(1);
      end
      if (state == S_LATCH) begin
        pot_r  <= potential_read_out;
        beta_r <= beta_read_out;
      end
    end
  end

  always_comb begin
    calc_pot = '0;
    calc_spk = '0;
    v = '0; c = '0; b = '0; sh = '0; leak = '0; sum = '0; sat = '0;
    for (int i = 0; i < NEURONS; i++) begin
      v    = pot_r[i*PW +: PW];
      b    = beta_r[i*BW +: BW];
      c    = cur_in[i*PW +: PW];
      sh   = (b > MAX_SH) ? 3'd7 : b[2:0];
      leak = v >>> sh;
      sum  = {{2{v[PW-1]}}, v} - {{2{leak[PW-1]}}, leak} + {{2{c[PW-1]}}, c};
      if (sum > SAT_MAX)      sat = SAT_MAX[PW-1:0];
      else if (sum < SAT_MIN) sat = SAT_MIN[PW-1:0];
      else                    sat = sum[PW-1:0];
      if (sat >= thr_r) begin
        calc_spk[i]           = 1'b1;
        calc_pot[i*PW +: PW]  = '0;
      end else begin
        calc_pot[i*PW +: PW]  = sat;
      end
    end
  end

endmodule

// File: tb/tb_lif_row_updater.sv
// Directed bench for lif_row_updater: a 1-cycle-latency row source stands in for the SRAM,
// a negedge monitor logs strobes, and hand-computed expectations are checked with assertions.
module tb_lif_row_updater;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [8:0]   base_addr, num_rows;
  logic [7:0]   threshold;
  logic [127:0] potential_read_out;
  logic [63:0]  beta_read_out;
  logic [127:0] cur_in;
  logic         cur_valid, cur_ready;
  logic [8:0]   cntrl_potential_read_addr, cntrl_beta_read_addr, cntrl_potential_write_addr;
  logic [127:0] potential_write_in;
  logic         potential_write_en;
  logic [15:0]  spk_row;
  logic         spk_valid, busy, done;

  logic [127:0] pot_row;
  logic [63:0]  beta_row;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int wr_cnt = 0, done_cnt = 0, busy_cnt = 0, ready_cnt = 0, bad_coinc = 0, done_cyc = 0;
  logic [8:0]   last_waddr;
  logic [127:0] last_wdata;
  logic [15:0]  last_spk;
  logic [8:0]   wr_addrs[$];

  lif_row_updater dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .threshold(threshold), .potential_read_out(potential_read_out),
    .beta_read_out(beta_read_out), .cur_in(cur_in), .cur_valid(cur_valid),
    .cur_ready(cur_ready), .cntrl_potential_read_addr(cntrl_potential_read_addr),
    .cntrl_beta_read_addr(cntrl_beta_read_addr),
    .cntrl_potential_write_addr(cntrl_potential_write_addr),
    .potential_write_in(potential_write_in), .potential_write_en(potential_write_en),
    .spk_row(spk_row), .spk_valid(spk_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    potential_read_out <= pot_row;
    beta_read_out      <= beta_row;
  end

  always @(negedge clk) begin
    if (potential_write_en) begin
      wr_cnt++;
      last_waddr = cntrl_potential_write_addr;
      last_wdata = potential_write_in;
      last_spk   = spk_row;
      wr_addrs.push_back(cntrl_potential_write_addr);
    end
    if (potential_write_en !== spk_valid) bad_coinc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc + 1;
    end
    if (busy) busy_cnt++;
    if (cur_ready) ready_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns just after the start edge k; sweep inputs are then scrambled to prove they were latched.
  task automatic start_sweep(input logic [8:0] base, input logic [8:0] rows,
                             input logic [7:0] thr, output int k);
    @(negedge clk);
    base_addr = base; num_rows = rows; threshold = thr; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0; base_addr = 9'h0AB; num_rows = 9'd7; threshold = 8'h80;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", done_cnt != prev, 1);
  endtask

  task automatic find_calc(input logic [8:0] addr, output bit found);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (cur_ready && cntrl_potential_read_addr == addr) found = 1'b1;
    end
  endtask

  initial begin
    int k, d0, w0, b0, r0;
    bit found;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; threshold = '0;
    cur_valid = 1'b0; cur_in = '0; pot_row = '0; beta_row = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addrs", {cntrl_potential_read_addr, cntrl_beta_read_addr, cntrl_potential_write_addr}, 0);
    check("rst_wdata", potential_write_in, 0);
    check("rst_ctl", {potential_write_en, spk_row, spk_valid, cur_ready, busy, done}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Basic fire: 40 - 20 + 35 = 55 >= 50
    pot_row = {16{8'd40}}; beta_row = {16{4'd1}}; cur_in = {16{8'd35}}; cur_valid = 1'b1;
    d0 = done_cnt; w0 = wr_cnt; b0 = busy_cnt; r0 = ready_cnt;
    start_sweep(9'd5, 9'd1, 8'd50, k);
    check("t1_raddr", cntrl_potential_read_addr, 5);
    check("t1_baddr", cntrl_beta_read_addr, 5);
    check("t1_busy_now", busy, 1);
    wait_done(d0, 40);
    check("t1_done_lat", done_cyc - k, 5);
    check("t1_waddr", last_waddr, 5);
    check("t1_wdata", last_wdata, 0);
    check("t1_spk", last_spk, 16'hFFFF);
    check("t1_writes", wr_cnt - w0, 1);
    check("t1_busy_cycles", busy_cnt - b0, 5);
    check("t1_ready_cycles", ready_cnt - r0, 1);

    // Leak, no fire: -64 - (-16) + 0 = -48
    pot_row = {16{8'hC0}}; beta_row = {16{4'd2}}; cur_in = '0;
    d0 = done_cnt;
    start_sweep(9'd100, 9'd1, 8'd10, k);
    wait_done(d0, 40);
    check("t2_wdata", last_wdata, {16{8'hD0}});
    check("t2_spk", last_spk, 16'h0000);
    check("t2_waddr", last_waddr, 100);

    // Per-neuron current 4*i, beta 0 so s = c; neurons 8..15 reach 30
    pot_row = '0; beta_row = '0;
    cur_in = 128'h3C38_3430_2C28_2420_1C18_1410_0C08_0400;
    d0 = done_cnt;
    start_sweep(9'd200, 9'd1, 8'd30, k);
    wait_done(d0, 40);
    check("t2b_wdata", last_wdata, 128'h0000_0000_0000_0000_1C18_1410_0C08_0400);
    check("t2b_spk", last_spk, 16'hFF00);

    // High saturation: 127 - 0 + 127 -> 127 >= 127
    pot_row = {16{8'h7F}}; beta_row = {16{4'hF}}; cur_in = {16{8'h7F}};
    d0 = done_cnt;
    start_sweep(9'd3, 9'd1, 8'h7F, k);
    wait_done(d0, 40);
    check("t3a_wdata", last_wdata, 0);
    check("t3a_spk", last_spk, 16'hFFFF);

    // Low saturation: -128 - (-1) - 128 -> -128, fires against threshold -128
    pot_row = {16{8'h80}}; cur_in = {16{8'h80}};
    d0 = done_cnt;
    start_sweep(9'd4, 9'd1, 8'h80, k);
    wait_done(d0, 40);
    check("t3b_wdata", last_wdata, 0);
    check("t3b_spk", last_spk, 16'hFFFF);

    d0 = done_cnt;
    start_sweep(9'd4, 9'd1, 8'h7F, k);
    wait_done(d0, 40);
    check("t3c_wdata", last_wdata, {16{8'h80}});
    check("t3c_spk", last_spk, 16'h0000);

    // Wrap 510, 511, 0 with a 5-cycle stall on row 511
    pot_row = '0; beta_row = '0; cur_in = '0;
    wr_addrs.delete();
    d0 = done_cnt; r0 = ready_cnt;
    start_sweep(9'd510, 9'd3, 8'd1, k);
    check("t4_raddr0", cntrl_potential_read_addr, 510);
    find_calc(9'd511, found);
    check("t4_found_calc511", found, 1);
    cur_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_ready", cur_ready, 1);
    end
    cur_valid = 1'b1;
    wait_done(d0, 80);
    check("t4_done_lat", done_cyc - k, 18);
    check("t4_nwrites", wr_addrs.size(), 3);
    check("t4_wr0", wr_addrs[0], 510);
    check("t4_wr1", wr_addrs[1], 511);
    check("t4_wr2", wr_addrs[2], 0);
    check("t4_ready_cycles", ready_cnt - r0, 8);

    // Empty sweep
    d0 = done_cnt; w0 = wr_cnt; b0 = busy_cnt;
    start_sweep(9'd50, 9'd0, 8'd0, k);
    check("t5_done_now", done, 1);
    wait_done(d0, 10);
    check("t5_done_lat", done_cyc - k, 1);
    repeat (5) @(negedge clk);
    #1;
    check("t5_writes", wr_cnt - w0, 0);
    check("t5_busy", busy_cnt - b0, 0);
    check("t5_dones", done_cnt - d0, 1);

    // Start while busy is ignored
    d0 = done_cnt; w0 = wr_cnt;
    start_sweep(9'd60, 9'd1, 8'd1, k);
    @(negedge clk);
    start = 1'b1; base_addr = 9'd70; num_rows = 9'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("t5b_dones", done_cnt - d0, 1);
    check("t5b_writes", wr_cnt - w0, 1);
    check("t5b_waddr", last_waddr, 60);

    // Reset during CALC of the third row
    d0 = done_cnt; w0 = wr_cnt;
    start_sweep(9'd20, 9'd3, 8'd1, k);
    find_calc(9'd22, found);
    check("t6_found_calc22", found, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_addrs", {cntrl_potential_read_addr, cntrl_beta_read_addr, cntrl_potential_write_addr}, 0);
    check("t6_rst_wdata", potential_write_in, 0);
    check("t6_rst_ctl", {potential_write_en, spk_row, spk_valid, cur_ready, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t6_writes", wr_cnt - w0, 2);
    check("t6_no_done", done_cnt - d0, 0);

    pot_row = {16{8'd40}}; beta_row = {16{4'd1}}; cur_in = {16{8'd35}};
    d0 = done_cnt; w0 = wr_cnt;
    start_sweep(9'd7, 9'd1, 8'd50, k);
    wait_done(d0, 40);
    check("t6_done_lat", done_cyc - k, 5);
    check("t6_waddr", last_waddr, 7);
    check("t6_spk", last_spk, 16'hFFFF);
    check("t6_writes_after", wr_cnt - w0, 1);

    check("coincident_strobes", bad_coinc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_row_updater.md
# lif_row_updater

Sequencer and leaky-integrate-and-fire datapath that sweeps rows of the neuron potential SRAM through the neuron selector. Per row it reads 16 potentials and 16 leak shifts, adds one row of synaptic current from the accumulator, thresholds, emits 16 spikes and writes updated potentials back. It sits directly upstream of the neuron selector: it drives `cntrl_potential_read_addr`, `cntrl_beta_read_addr` and `cntrl_potential_write_addr`/`potential_write_in`, and consumes `potential_read_out`/`beta_read_out`.

## Interface
- Clock is `clk`; reset is `rst_n`, asynchronous, active-low.
- NEURONS, 16, neurons per SRAM row
- PW, 8, signed potential and current width per neuron
- BW, 4, unsigned leak-shift width per neuron
- AW, 9, SRAM row address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep, sampled only in IDLE
- base_addr  in  AW  first row of the sweep
- num_rows  in  AW  rows to process; 0 means an empty sweep
- threshold  in  PW  signed firing threshold
- potential_read_out  in  NEURONS*PW  potential row from the selector
- beta_read_out  in  NEURONS*BW  beta row from the selector
- cur_in  in  NEURONS*PW  signed current row from the accumulator
- cur_valid  in  1  cur_in is valid
- cur_ready  out  1  updater accepts cur_in this cycle
- cntrl_potential_read_addr  out  AW  potential read row
- cntrl_beta_read_addr  out  AW  beta read row (always equal to the potential read row)
- cntrl_potential_write_addr  out  AW  write-back row
- potential_write_in  out  NEURONS*PW  updated potential row
- potential_write_en  out  1  one-cycle write strobe
- spk_row  out  NEURONS  spikes of the row just written; bit i is neuron i
- spk_valid  out  1  spk_row is valid
- busy  out  1  high from READ until DONE, inclusive
- done  out  1  one-cycle pulse at the end of a sweep

## Operation
- States and transitions:
  - IDLE: if start=1 and num_rows=0, go to DONE. If start=1 and num_rows≠0, latch base_addr/num_rows/threshold, set the row index to 0 and go to READ.
  - READ → LATCH.
  - LATCH → CALC.
  - CALC → WRITE when cur_valid is high; otherwise stay in CALC.
  - WRITE → DONE on the last row; otherwise go to READ.
  - DONE → IDLE.
- READ: registered read addresses = (base + row index) mod 2^AW. Wrap-around past row 511 is legal.
- LATCH: the SRAM has 1-cycle read latency. Capture potential_read_out and beta_read_out into internal registers. Addresses are held.
- CALC: cur_ready=1. On cur_valid & cur_ready, compute for each neuron i:
  - v = signed potential, b = beta (0..15), c = signed current.
  - leak = v >>> min(b,7) (arithmetic shift).
  - s = v − leak + c, computed in PW+2 bits and saturated to [−128, 127].
  - If s ≥ threshold (signed): spike_i=1 and v' = 0. Otherwise spike_i=0 and v' = s.
  - Register v' and the spikes.
- WRITE: potential_write_en=1, write address = current row, spk_valid=1. Then increment the row index.
- DONE: done=1 for one cycle.
- start is ignored in every state except IDLE.
- Inputs base_addr/num_rows/threshold may change mid-sweep without effect.
- cur_in is not consumed outside CALC.
- Reset mid-sweep: return immediately to IDLE with every output at its reset value. No write strobe; no partial done.

## Timing
- Reset values: all addresses 0, potential_write_in 0, potential_write_en 0, spk_row 0, spk_valid 0, cur_ready 0, busy 0, done 0.
- start high at edge k → READ in cycle k+1, with the read address valid in that cycle.
- No stalls: 4 cycles per row (READ, LATCH, CALC, WRITE). A sweep of N rows raises done at cycle k+4N+1 relative to the start edge.
- Empty sweep: done pulses in cycle k+1 and busy stays 0.
- Each CALC stall cycle adds one cycle.
- potential_write_en, spk_valid and spk_row are coincident, for one cycle only.
- The write address equals the read address of the same row.
- All outputs are registered.
- cur_ready is high in every CALC cycle, including stall cycles. A handshake completes on the edge where cur_valid & cur_ready are both high.

## Test plan
- Basic fire: base=5, rows=1, threshold=50; all v=40, beta=1, c=35 → s=55, all spikes. Expect write addr 5, data all 0, spk_row=16'hFFFF, done at k+5.
- Leak/no fire: v=−64, b=2, c=0, threshold=10 → leak=−16, s=−48. Expect write data −48 (8'hD0) per neuron and spk_row=0.
- Saturation: v=127, b=15, c=127, threshold=127 → leak=0, s saturates to 127, which is ≥127. Expect spike=1 and v'=0. Rerun with threshold=−128 and v=−128, c=−128: expect −128 saturate and spike=1.
- Wrap and stall: base=510, rows=3 → read/write rows 510, 511, 0. Hold cur_valid low 5 cycles on row 511 → done at k+18.
- Empty sweep, and start while busy: rows=0 → done at k+1 with no strobes. A second start during busy is ignored; exactly one done is seen.
- Reset mid-sweep: assert rst_n low during CALC of row 2 → outputs reset immediately. After release, a new start=1 sweep of 1 row completes normally.
